// File: rtl/muldiv_scheduler.sv
// muldiv_scheduler: issues mul/div to external units and commits HI/LO; optional MULDIV_DIV0_BYPASS_EN
// answers divide-by-zero directly (hi=op_a, lo=all ones) without using the divider.
module muldiv_scheduler (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        issue_mul,
    input  logic        issue_div,
    input  logic        op_sign,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic [31:0] mt_data,
    input  logic        rd_hilo,
    output logic [31:0] unit_a,
    output logic [31:0] unit_b,
    output logic        unit_sign,
    output logic        mul_start,
    output logic        div_start,
    input  logic        mul_done,
    input  logic [63:0] mul_prod,
    input  logic        div_done,
    input  logic [31:0] div_q,
    input  logic [31:0] div_r,
    output logic        stall,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    typedef enum logic [1:0] {IDLE, MUL_WAIT, DIV_WAIT, COMMIT} state_t;
    state_t      state;
    logic [31:0] hi_n, lo_n;

    assign busy  = state != IDLE;
    assign stall = busy & (issue_mul | issue_div | mthi | mtlo | rd_hilo);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            unit_a    <= '0;
            unit_b    <= '0;
            unit_sign <= 1'b0;
            mul_start <= 1'b0;
            div_start <= 1'b0;
            hi        <= '0;
            lo        <= '0;
            hi_n      <= '0;
            lo_n      <= '0;
        end else begin
            mul_start <= 1'b0;
            div_start <= 1'b0;
            case (state)
                IDLE:
                    if (issue_mul || issue_div) begin
                        unit_a    <= op_a;
                        unit_b    <= op_b;
                        unit_sign <= op_sign;
                        if (issue_mul) begin
                            mul_start <= 1'b1;
                            state     <= MUL_WAIT;
                        end
`ifdef MULDIV_DIV0_BYPASS_EN
                        else if (op_b == '0) begin
                            hi_n  <= op_a;
                            lo_n  <= '1;
                            state <= COMMIT;
                        end
`endif
                        else begin
                            div_start <= 1'b1;
                            state     <= DIV_WAIT;
                        end
                    end else begin
                        if (mthi) hi <= mt_data;
                        if (mtlo) lo <= mt_data;
                    end
                MUL_WAIT:
                    if (mul_done) begin
                        {hi_n, lo_n} <= mul_prod;
                        state        <= COMMIT;
                    end
                DIV_WAIT:
                    if (div_done) begin
                        hi_n  <= div_r;
                        lo_n  <= div_q;
                        state <= COMMIT;
                    end
                default: begin
                    hi    <= hi_n;
                    lo    <= lo_n;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
